// File: rtl/result_if.sv
// ============================================================================
// Module   : result_if
// Purpose  : Valid/ready result handshake from the classifier to result_indicator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface result_if;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] result_class;
  logic [3:0] expected_class;

  modport master (
    output result_valid,
    output result_class,
    output expected_class,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_class,
    input  expected_class,
    output result_ready
  );
endinterface

`default_nettype wire

// File: rtl/result_indicator.sv
// ============================================================================
// Module   : result_indicator
// Purpose  : Compares the classifier digit with the switch setting and shows
//            match (solid LED) or miss (blinking LED) for FREQUENCY cycles.
//            Define RESULT_SEG_EN to build the seven-segment decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module result_indicator #(
  parameter int FREQUENCY = 50000000,
  parameter int BLINK_DIV = 5000000
) (
  input  wire        clk,
  input  wire        rst_n,
  result_if.slave    res,
  output logic       led_match_n,
  output logic       led_miss_n,
  output logic [7:0] seg_n,
  output logic       match_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int          c_blk_w    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] c_cnt_last = 32'(FREQUENCY - 1);
  localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_DIV - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_cnt;
  logic [31:0]          w_cnt_nxt;
  logic [c_blk_w-1:0]   r_blk;
  logic [c_blk_w-1:0]   w_blk_nxt;
  logic                 r_phase;
  logic                 w_phase_nxt;
  logic                 r_match;
  logic [3:0]           r_class;
  logic [3:0]           r_expected;
  logic                 r_led_match_n;
  logic                 w_led_match_n_nxt;
  logic                 r_led_miss_n;
  logic                 w_led_miss_n_nxt;
  logic                 r_pulse;
  logic                 w_pulse_nxt;
  logic                 r_busy;
  logic                 r_ready;
  logic                 w_accept;
  logic                 w_match;
  logic                 w_load;
  logic                 w_cnt_last;
  logic                 w_blk_wrap;

  assign w_accept   = res.result_valid && r_ready;
  assign w_match    = (r_class == r_expected) && (r_class <= 4'd9);
  assign w_cnt_last = (r_cnt == c_cnt_last);
  assign w_blk_wrap = (r_blk == c_blk_last);

  // Output registers are loaded with the value they must show in the next state,
  // so every output is a flop with no combinational input path.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_blk_nxt         = r_blk;
    w_phase_nxt       = r_phase;
    w_led_match_n_nxt = 1'b1;
    w_led_miss_n_nxt  = 1'b1;
    w_pulse_nxt       = 1'b0;
    w_load            = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = LATCH;
      end
      LATCH: begin
        w_state_nxt       = SHOW;
        w_cnt_nxt         = 32'd0;
        w_blk_nxt         = '0;
        w_phase_nxt       = 1'b0;
        w_led_match_n_nxt = ~w_match;
        w_led_miss_n_nxt  = w_match;
        w_pulse_nxt       = w_match;
        w_load            = 1'b1;
      end
      SHOW: begin
        if (w_accept) begin
          w_state_nxt = LATCH;
        end else if (w_cnt_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt         = r_cnt + 32'd1;
          w_blk_nxt         = w_blk_wrap ? '0 : r_blk + 1'b1;
          w_phase_nxt       = r_phase ^ w_blk_wrap;
          w_led_match_n_nxt = ~r_match;
          w_led_miss_n_nxt  = r_match | (r_phase ^ w_blk_wrap);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= 32'd0;
      r_blk         <= '0;
      r_phase       <= 1'b0;
      r_match       <= 1'b0;
      r_class       <= 4'd0;
      r_expected    <= 4'd0;
      r_led_match_n <= 1'b1;
      r_led_miss_n  <= 1'b1;
      r_pulse       <= 1'b0;
      r_busy        <= 1'b0;
      r_ready       <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_blk         <= w_blk_nxt;
      r_phase       <= w_phase_nxt;
      r_led_match_n <= w_led_match_n_nxt;
      r_led_miss_n  <= w_led_miss_n_nxt;
      r_pulse       <= w_pulse_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_ready       <= (w_state_nxt != LATCH);
      if (w_load) r_match <= w_match;
      if (w_accept) begin
        r_class    <= res.result_class;
        r_expected <= res.expected_class;
      end
    end
  end

`ifdef RESULT_SEG_EN
  logic [7:0] r_seg_n;
  logic [7:0] w_seg_dec;

  always_comb begin
    w_seg_dec = 8'hBF;
    case (r_class)
      4'd0:    w_seg_dec = 8'hC0;
      4'd1:    w_seg_dec = 8'hF9;
      4'd2:    w_seg_dec = 8'hA4;
      4'd3:    w_seg_dec = 8'hB0;
      4'd4:    w_seg_dec = 8'h99;
      4'd5:    w_seg_dec = 8'h92;
      4'd6:    w_seg_dec = 8'h82;
      4'd7:    w_seg_dec = 8'hF8;
      4'd8:    w_seg_dec = 8'h80;
      4'd9:    w_seg_dec = 8'h90;
      default: w_seg_dec = 8'hBF;
    endcase
  end

  // A lit decimal point marks a miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_n <= 8'hFF;
    end else if (w_load) begin
      r_seg_n <= w_match ? w_seg_dec : (w_seg_dec & 8'h7F);
    end
  end

  assign seg_n = r_seg_n;
`else
  assign seg_n = 8'hFF;
`endif

  assign res.result_ready = r_ready;
  assign led_match_n      = r_led_match_n;
  assign led_miss_n       = r_led_miss_n;
  assign match_pulse      = r_pulse;
  assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_result_indicator.sv
// ============================================================================
// Module   : tb_result_indicator
// Purpose  : Directed self-checking bench for result_indicator (FREQUENCY=20,
//            BLINK_DIV=4); segment expectations follow RESULT_SEG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_result_indicator;

  localparam int c_freq = 20;
  localparam int c_div  = 4;

  logic       clk;
  logic       rst_n;
  logic       led_match_n;
  logic       led_miss_n;
  logic [7:0] seg_n;
  logic       match_pulse;
  logic       busy;
  int         n_vec;
  int         n_miss;

  result_if bus ();

  result_indicator #(
    .FREQUENCY (c_freq),
    .BLINK_DIV (c_div)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res         (bus),
    .led_match_n (led_match_n),
    .led_miss_n  (led_miss_n),
    .seg_n       (seg_n),
    .match_pulse (match_pulse),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_exp(input logic [7:0] v);
`ifdef RESULT_SEG_EN
    return v;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] seg);
    check({tag, " led_match_n"}, 32'(led_match_n), 32'd1);
    check({tag, " led_miss_n"},  32'(led_miss_n),  32'd1);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " ready"},       32'(bus.result_ready), 32'd1);
    check({tag, " pulse"},       32'(match_pulse), 32'd0);
    check({tag, " seg_n"},       32'(seg_n),       32'(seg));
  endtask

  // Called just after a falling edge; the next rising edge accepts.
  task automatic send(input logic [3:0] c, input logic [3:0] e);
    bus.result_valid   = 1'b1;
    bus.result_class   = c;
    bus.expected_class = e;
    @(negedge clk);
    bus.result_valid = 1'b0;
    check("latch busy",        32'(busy),             32'd1);
    check("latch ready",       32'(bus.result_ready), 32'd0);
    check("latch led_match_n", 32'(led_match_n),      32'd1);
    check("latch led_miss_n",  32'(led_miss_n),       32'd1);
    check("latch pulse",       32'(match_pulse),      32'd0);
  endtask

  task automatic show_cycles(input bit m, input logic [7:0] seg, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      check($sformatf("show k%0d led_match_n", k), 32'(led_match_n), m ? 32'd0 : 32'd1);
      check($sformatf("show k%0d led_miss_n", k),  32'(led_miss_n),
            m ? 32'd1 : 32'((k / c_div) % 2));
      check($sformatf("show k%0d pulse", k),       32'(match_pulse), 32'(m && (k == 0)));
      check($sformatf("show k%0d seg_n", k),       32'(seg_n),       32'(seg_exp(seg)));
      check($sformatf("show k%0d busy", k),        32'(busy),        32'd1);
      check($sformatf("show k%0d ready", k),       32'(bus.result_ready), 32'd1);
    end
  endtask

  initial begin
    n_vec              = 0;
    n_miss             = 0;
    rst_n              = 1'b0;
    bus.result_valid   = 1'b0;
    bus.result_class   = 4'd0;
    bus.expected_class = 4'd0;

    repeat (3) @(negedge clk);
    check_idle("reset", 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post-reset", 8'hFF);

    // match 7 == 7
    send(4'd7, 4'd7);
    show_cycles(1'b1, 8'hF8, 0, c_freq - 1);
    @(negedge clk);
    check_idle("match end", seg_exp(8'hF8));

    // miss 3 vs 5
    send(4'd3, 4'd5);
    show_cycles(1'b0, 8'h30, 0, c_freq - 1);
    @(negedge clk);
    check_idle("miss end", seg_exp(8'h30));

    // invalid digit is always a miss
    send(4'd12, 4'd12);
    show_cycles(1'b0, 8'h3F, 0, c_freq - 1);
    @(negedge clk);
    check_idle("invalid end", seg_exp(8'h3F));

    // retrigger at cnt = 10
    send(4'd7, 4'd7);
    show_cycles(1'b1, 8'hF8, 0, 10);
    send(4'd2, 4'd9);
    show_cycles(1'b0, 8'h24, 0, c_freq - 1);
    @(negedge clk);
    check_idle("retrigger end", seg_exp(8'h24));

    // accept on the last SHOW cycle wins over the return to IDLE
    send(4'd1, 4'd1);
    show_cycles(1'b1, 8'hF9, 0, c_freq - 1);
    send(4'd0, 4'd0);
    show_cycles(1'b1, 8'hC0, 0, 2);

    // mid-operation reset at cnt = 5 of the running match
    show_cycles(1'b1, 8'hC0, 3, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid reset", 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after mid reset", 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
